// File: rtl/rr_arb_mux.sv
// ============================================================================
// Module   : rr_arb_mux
// Purpose  : N-channel arbitrated mux with a registered output and valid/ready
//            on every port. Round-robin or fixed-priority arbitration.
// Option   : define RR_ARB_MUX_PKT_LOCK_EN for packet-locked arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    localparam int CHW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHW-1:0]       out_ch,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last,
`endif
    input  logic                 out_ready
);

    logic [CHW-1:0]   r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CHW-1:0]   r_out_ch;

    logic             w_can_load;
    logic             w_gnt_vld;
    logic [CHW-1:0]   w_gnt;
    logic             w_load;
    logic [WIDTH-1:0] w_sel_data;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic             r_lock;
    logic             r_out_last;
    logic             w_sel_last;
`endif

    assign w_can_load = !r_out_valid || out_ready;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (mode) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = CHW'(i);
                end
            end
        end else begin
            // Scan ptr+1 .. ptr (inclusive) modulo NCH; the first hit wins.
            for (int k = 1; k <= NCH; k++) begin
                if (!w_gnt_vld && in_valid[(int'(r_ptr) + k) % NCH]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = CHW'((int'(r_ptr) + k) % NCH);
                end
            end
        end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // An open packet keeps the channel that started it.
        if (r_lock) begin
            w_gnt_vld = in_valid[r_ptr];
            w_gnt     = r_ptr;
        end
`endif
    end

    assign w_load = w_can_load && w_gnt_vld && !rst;

    always_comb begin
        w_sel_data = '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        w_sel_last = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (CHW'(i) == w_gnt) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
`ifdef RR_ARB_MUX_PKT_LOCK_EN
                w_sel_last = in_last[i];
`endif
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_load && (CHW'(i) == w_gnt)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= CHW'(NCH - 1);
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt;
            r_ptr       <= w_gnt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_lock     <= !w_sel_last;
            r_out_last <= w_sel_last;
        end
    end

    assign out_last = r_out_last;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// Directed test of rr_arb_mux (WIDTH=32, NCH=4) with hand-computed expectations.
`default_nettype none

module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [NCH-1:0]     in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]     in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_ch;
    logic               out_ready;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic [NCH-1:0]     in_last;
    logic               out_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".ch"},    32'(out_ch), 32'(c));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = '0; out_ready = 1'b1;
        in_data = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        in_last = 4'b1111;
`endif
        step();
        step();
        chk_out("reset", 1'b0, 32'h0, 2'd0);

        // Round-robin over four always-valid channels, no bubbles
        rst = 1'b0; in_valid = 4'b1111;
        #1;
        chk("rr.rdy0", 32'(in_ready), 32'b0001);
        step(); chk_out("rr0", 1'b1, 32'h1000, 2'd0);
        chk("rr.rdy1", 32'(in_ready), 32'b0010);
        step(); chk_out("rr1", 1'b1, 32'h1001, 2'd1);
        step(); chk_out("rr2", 1'b1, 32'h1002, 2'd2);
        step(); chk_out("rr3", 1'b1, 32'h1003, 2'd3);
        step(); chk_out("rr4", 1'b1, 32'h1000, 2'd0);

        // Fixed priority starves ch3; back to round-robin alternates 3,1,3
        mode = 1'b1; in_valid = 4'b1010;
        #1;
        chk("fp.rdy", 32'(in_ready), 32'b0010);
        step(); chk_out("fp0", 1'b1, 32'h1001, 2'd1);
        step(); chk_out("fp1", 1'b1, 32'h1001, 2'd1);
        step(); chk_out("fp2", 1'b1, 32'h1001, 2'd1);
        mode = 1'b0;
        #1;
        chk("sw.rdy", 32'(in_ready), 32'b1000);
        step(); chk_out("sw0", 1'b1, 32'h1003, 2'd3);
        step(); chk_out("sw1", 1'b1, 32'h1001, 2'd1);
        step(); chk_out("sw2", 1'b1, 32'h1003, 2'd3);

        // Backpressure: hold 0xAA from ch2 for five stalled cycles
        in_data[2*WIDTH +: WIDTH] = 32'hAA;
        in_valid = 4'b0100;
        step(); chk_out("bp.load", 1'b1, 32'hAA, 2'd2);
        out_ready = 1'b0; in_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.rdy", 32'(in_ready), 32'b0000);
            step(); chk_out("bp.hold", 1'b1, 32'hAA, 2'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_rel", 32'(in_ready), 32'b0001);
        step(); chk_out("bp.drain_load", 1'b1, 32'h1000, 2'd0);

        // Single beat from ch3, then idle: one valid cycle, data retained
        in_data[3*WIDTH +: WIDTH] = 32'h3333;
        in_valid = 4'b1000;
        step(); chk_out("one.load", 1'b1, 32'h3333, 2'd3);
        in_valid = 4'b0000;
        step(); chk_out("one.drain", 1'b0, 32'h3333, 2'd3);
        step(); chk_out("one.idle", 1'b0, 32'h3333, 2'd3);

        // Reset with a stalled beat in the output register
        in_valid = 4'b0010; out_ready = 1'b0;
        step(); chk_out("rs.load", 1'b1, 32'h1001, 2'd1);
        rst = 1'b1; in_valid = 4'b1111;
        #1;
        chk("rs.rdy", 32'(in_ready), 32'b0000);
        step(); chk_out("rs.clear", 1'b0, 32'h0, 2'd0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rs.rdy_first", 32'(in_ready), 32'b0001);
        step(); chk_out("rs.first", 1'b1, 32'h1000, 2'd0);

`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // ch1 sends a 3-beat packet while ch0 and ch2 wait
        in_valid = 4'b0111;
        in_last  = 4'b1101;
        step(); chk_out("pk.b0", 1'b1, 32'h1001, 2'd1);
        chk("pk.b0.last", 32'(out_last), 32'd0);
        step(); chk_out("pk.b1", 1'b1, 32'h1001, 2'd1);
        chk("pk.b1.last", 32'(out_last), 32'd0);
        in_last = 4'b1111;
        step(); chk_out("pk.b2", 1'b1, 32'h1001, 2'd1);
        chk("pk.b2.last", 32'(out_last), 32'd1);
        step(); chk_out("pk.ch2", 1'b1, 32'hAA, 2'd2);
        step(); chk_out("pk.ch0", 1'b1, 32'h1000, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
